// File: rtl/apb_timer_pkg.sv
// Shared definitions for the APB timer: register word offsets, CTRL bit layout
// and the packed CTRL struct with helpers to move it to and from a bus word.
package apb_timer_pkg;

    localparam logic [1:0] TMR_CTRL   = 2'd0;
    localparam logic [1:0] TMR_LOAD   = 2'd1;
    localparam logic [1:0] TMR_VALUE  = 2'd2;
    localparam logic [1:0] TMR_STATUS = 2'd3;

    localparam int CTRL_EN_BIT       = 0;
    localparam int CTRL_PERIODIC_BIT = 1;
    localparam int CTRL_IRQ_EN_BIT   = 2;
    localparam int CTRL_PRESC_LSB    = 8;
    localparam int CTRL_PRESC_MSB    = 15;

    typedef struct packed {
        logic [7:0] presc;
        logic       irq_en;
        logic       periodic;
        logic       en;
    } ctrl_t;

    function automatic ctrl_t ctrl_from_word(input logic [31:0] w);
        ctrl_t c;
        c.presc    = w[CTRL_PRESC_MSB:CTRL_PRESC_LSB];
        c.irq_en   = w[CTRL_IRQ_EN_BIT];
        c.periodic = w[CTRL_PERIODIC_BIT];
        c.en       = w[CTRL_EN_BIT];
        return c;
    endfunction

    function automatic logic [31:0] ctrl_to_word(input ctrl_t c);
        logic [31:0] w;
        w = '0;
        w[CTRL_PRESC_MSB:CTRL_PRESC_LSB] = c.presc;
        w[CTRL_IRQ_EN_BIT]               = c.irq_en;
        w[CTRL_PERIODIC_BIT]             = c.periodic;
        w[CTRL_EN_BIT]                   = c.en;
        return w;
    endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Prescaler for the APB timer: counts 0..presc while enabled and emits a
// one-cycle tick on the terminal count, then wraps to 0.
module timer_prescaler (
    input  logic       clk,
    input  logic       hresetn,
    input  logic       en,
    input  logic       clr,
    input  logic [7:0] presc,
    output logic       tick
);

    logic [7:0] count;

    assign tick = en & (count == presc);

    // clr beats everything so a LOAD write or a fresh enable restarts the period
    always_ff @(posedge clk or negedge hresetn) begin
        if (!hresetn) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (tick) begin
            count <= '0;
        end else if (en) begin
            count <= count + 8'd1;
        end
    end

endmodule

// File: rtl/apb_timer_slave.sv
// APB timer slave: zero-wait APB decode of CTRL/LOAD/VALUE/STATUS, a prescaled
// down-counter with one-shot or periodic reload, sticky expiry and level irq.
module apb_timer_slave
    import apb_timer_pkg::*;
#(
    parameter int          PSEL_IDX   = 0,
    parameter logic [31:0] RESET_LOAD = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        hresetn,
    input  logic [2:0]  psel,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [31:0] paddr,
    input  logic [31:0] pwdata,
    output logic [31:0] prdata,
    output logic        irq
);

    // Handshake: a transfer is a setup cycle (sel & ~penable) followed by one
    // access cycle (sel & penable); there is no ready, so every access completes.
    logic        sel;
    logic        wr;
    logic        rd_setup;
    logic        access;
    logic [1:0]  reg_idx;
    logic        wr_ctrl;
    logic        wr_load;
    logic        wr_status;
    ctrl_t       ctrl;
    ctrl_t       wctrl;
    logic [31:0] load;
    logic [31:0] value;
    logic        expired;
    logic        tick;
    logic        presc_clr;
    logic        expire;
    logic [31:0] rdata;
    logic        unused_bits;

    assign sel       = psel[PSEL_IDX];
    assign wr        = sel & penable & pwrite;
    assign rd_setup  = sel & ~penable & ~pwrite;
    assign access    = sel & penable;
    assign reg_idx   = paddr[3:2];
    assign wr_ctrl   = wr & (reg_idx == TMR_CTRL);
    assign wr_load   = wr & (reg_idx == TMR_LOAD);
    assign wr_status = wr & (reg_idx == TMR_STATUS);
    assign wctrl     = ctrl_from_word(pwdata);

    assign unused_bits = ^{paddr[31:4], paddr[1:0], psel};

    assign presc_clr = wr_load | (wr_ctrl & ~ctrl.en & wctrl.en);
    // A LOAD write in the tick cycle replaces the count, so it cannot expire
    assign expire    = tick & ~wr_load & (value == 32'd0);

    timer_prescaler u_prescaler (
        .clk     (clk),
        .hresetn (hresetn),
        .en      (ctrl.en),
        .clr     (presc_clr),
        .presc   (ctrl.presc),
        .tick    (tick)
    );

    always_ff @(posedge clk or negedge hresetn) begin
        if (!hresetn) begin
            ctrl <= '0;
        end else if (wr_ctrl) begin
            ctrl <= wctrl;
        end else if (expire & ~ctrl.periodic) begin
            ctrl.en <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge hresetn) begin
        if (!hresetn) begin
            load <= RESET_LOAD;
        end else if (wr_load) begin
            load <= pwdata;
        end
    end

    always_ff @(posedge clk or negedge hresetn) begin
        if (!hresetn) begin
            value <= RESET_LOAD;
        end else if (wr_load) begin
            value <= pwdata;
        end else if (tick) begin
            if (value != 32'd0) begin
                value <= value - 32'd1;
            end else if (ctrl.periodic) begin
                value <= load;
            end
        end
    end

    always_ff @(posedge clk or negedge hresetn) begin
        if (!hresetn) begin
            expired <= 1'b0;
        end else begin
            expired <= expire | (expired & ~(wr_status & pwdata[0]));
        end
    end

    always_comb begin
        rdata = '0;
        case (reg_idx)
            TMR_CTRL:   rdata = ctrl_to_word(ctrl);
            TMR_LOAD:   rdata = load;
            TMR_VALUE:  rdata = value;
            TMR_STATUS: rdata = {31'd0, expired};
            default:    rdata = '0;
        endcase
    end

    // Captured at the setup edge, held through access, zero otherwise
    always_ff @(posedge clk or negedge hresetn) begin
        if (!hresetn) begin
            prdata <= '0;
        end else if (rd_setup) begin
            prdata <= rdata;
        end else if (!access) begin
            prdata <= '0;
        end
    end

    assign irq = expired & ctrl.irq_en;

endmodule

// File: tb/tb_apb_timer_slave.sv
// Directed and randomized bench for apb_timer_slave with an arithmetic model
// of the counter (ticks elapsed since enable) used to predict register reads.
module tb_apb_timer_slave;

    logic        clk = 1'b0;
    logic        hresetn = 1'b0;
    logic [2:0]  psel = 3'b000;
    logic        penable = 1'b0;
    logic        pwrite = 1'b0;
    logic [31:0] paddr = '0;
    logic [31:0] pwdata = '0;
    logic [31:0] prdata;
    logic        irq;

    logic [2:0]  sel_v = 3'b001;
    int          cyc = 0;
    int          t0 = 0;
    int          n_pass = 0;
    int          n_total = 0;
    int          n_fail = 0;

    int          m_load;
    int          m_presc;
    bit          m_per;

    apb_timer_slave dut (
        .clk     (clk),
        .hresetn (hresetn),
        .psel    (psel),
        .penable (penable),
        .pwrite  (pwrite),
        .paddr   (paddr),
        .pwdata  (pwdata),
        .prdata  (prdata),
        .irq     (irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Model: n clock edges after the enabling write, floor(n/(presc+1)) ticks
    // have occurred; expiry needs load+1 ticks.
    function automatic int m_ticks(input int n);
        return n / (m_presc + 1);
    endfunction

    function automatic logic [31:0] m_value(input int n);
        int k;
        k = m_ticks(n);
        if (k <= m_load) return 32'(m_load - k);
        if (m_per) return 32'(m_load - (k % (m_load + 1)));
        return 32'd0;
    endfunction

    function automatic logic m_expired(input int n);
        return m_ticks(n) >= m_load + 1;
    endfunction

    function automatic logic m_en(input int n);
        return m_per || (m_ticks(n) < m_load + 1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the access edge.
    task automatic apb_write(input logic [31:0] a, input logic [31:0] d);
        psel = sel_v; paddr = a; pwdata = d; pwrite = 1'b1; penable = 1'b0;
        @(negedge clk);
        penable = 1'b1;
        @(negedge clk);
        psel = 3'b000; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic apb_read(input logic [31:0] a, output logic [31:0] d);
        psel = sel_v; paddr = a; pwrite = 1'b0; penable = 1'b0;
        @(negedge clk);
        penable = 1'b1;
        d = prdata;
        @(negedge clk);
        psel = 3'b000; penable = 1'b0;
    endtask

    initial begin
        logic [31:0] d;
        logic [31:0] cw;
        int          n;

        repeat (3) @(negedge clk);
        chk("reset_prdata", prdata, 32'd0);
        hresetn = 1'b1;
        @(negedge clk);

        apb_read(32'h0, d); chk("reset_ctrl", d, 32'h0);
        apb_read(32'h4, d); chk("reset_load", d, 32'hFFFF_FFFF);
        apb_read(32'h8, d); chk("reset_value", d, 32'hFFFF_FFFF);
        apb_read(32'hC, d); chk("reset_status", d, 32'h0);
        chk("reset_irq", irq, 1'b0);
        chk("idle_prdata", prdata, 32'd0);

        // One-shot LOAD=3, presc=0: expiry 4 clocks after the enabling edge
        apb_write(32'h4, 32'd3);
        apb_write(32'h0, 32'h0000_0005);
        repeat (3) @(negedge clk);
        chk("oneshot_irq_before", irq, 1'b0);
        @(negedge clk);
        chk("oneshot_irq_rise", irq, 1'b1);
        apb_read(32'h0, d); chk("oneshot_ctrl_en_clr", d, 32'h0000_0004);
        apb_read(32'h8, d); chk("oneshot_value_hold", d, 32'd0);
        apb_read(32'hC, d); chk("oneshot_status", d, 32'd1);
        apb_write(32'hC, 32'd1);
        chk("w1c_irq_fall", irq, 1'b0);
        apb_read(32'hC, d); chk("w1c_status", d, 32'd0);

        // Periodic LOAD=1, presc=2: expiry edges every 6 clocks
        apb_write(32'h4, 32'd1);
        apb_write(32'h0, 32'h0000_0203);
        t0 = cyc; m_load = 1; m_presc = 2; m_per = 1'b1;
        while (cyc - t0 != 10) @(negedge clk);
        apb_write(32'hC, 32'd1);
        apb_read(32'hC, d); chk("w1c_vs_expiry", d, 32'd1);
        while ((cyc - t0) % 6 != 1) @(negedge clk);
        apb_write(32'hC, 32'd1);
        apb_read(32'hC, d); chk("w1c_clear_periodic", d, 32'd0);
        n = cyc - t0;
        apb_read(32'h8, d); chk("periodic_value", d, m_value(n));

        // LOAD write on a tick edge: the written value wins, no decrement
        while ((cyc - t0) % 3 != 1) @(negedge clk);
        apb_write(32'h4, 32'd5);
        t0 = cyc; m_load = 5;
        n = cyc - t0;
        apb_read(32'h8, d); chk("load_vs_tick", d, m_value(n));
        repeat (4) @(negedge clk);
        n = cyc - t0;
        apb_read(32'h8, d); chk("after_load_value", d, m_value(n));

        // Randomized configurations checked against the model
        for (int it = 0; it < 6; it++) begin
            m_load  = int'($urandom_range(0, 7));
            m_presc = int'($urandom_range(0, 3));
            m_per   = 1'($urandom_range(0, 1));
            cw = {16'd0, 8'(m_presc), 5'd0, 1'b1, m_per, 1'b1};
            apb_write(32'h0, 32'h0);
            apb_write(32'h4, 32'(m_load));
            apb_write(32'hC, 32'd1);
            apb_write(32'h0, cw);
            t0 = cyc;
            for (int r = 0; r < 3; r++) begin
                repeat ($urandom_range(0, 12)) @(negedge clk);
                n = cyc - t0;
                apb_read(32'h8, d); chk("rand_value", d, m_value(n));
            end
            n = cyc - t0;
            chk("rand_irq", irq, m_expired(n));
            apb_read(32'hC, d); chk("rand_status", d, {31'd0, m_expired(n)});
            n = cyc - t0;
            apb_read(32'h0, d); chk("rand_ctrl", d, {cw[31:1], m_en(n)});
        end

        // Transfer addressed to another slave: no effect, prdata stays 0
        sel_v = 3'b010;
        apb_write(32'h4, 32'h1234_5678);
        apb_read(32'h4, d); chk("other_slave_prdata", d, 32'd0);
        sel_v = 3'b001;
        apb_read(32'h4, d); chk("other_slave_load", d, 32'(m_load));

        // Reset during the access phase of a CTRL write
        psel = 3'b001; paddr = 32'h0; pwdata = 32'h0000_0005; pwrite = 1'b1; penable = 1'b0;
        @(negedge clk);
        penable = 1'b1;
        #2 hresetn = 1'b0;
        @(negedge clk);
        psel = 3'b000; penable = 1'b0; pwrite = 1'b0;
        chk("rst_irq", irq, 1'b0);
        chk("rst_prdata", prdata, 32'd0);
        hresetn = 1'b1;
        @(negedge clk);
        apb_read(32'h0, d); chk("rst_ctrl", d, 32'h0);
        apb_read(32'h4, d); chk("rst_load", d, 32'hFFFF_FFFF);
        apb_read(32'hC, d); chk("rst_status", d, 32'h0);
        repeat (5) @(negedge clk);
        apb_read(32'h8, d); chk("rst_value_stopped", d, 32'hFFFF_FFFF);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
